// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// FSM state encoding, the zero word and the default timeout.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } mac_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned MAX_DW          = 64;
    localparam logic [MAX_DW-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/mem_access_ctrl_timeout.sv
// WAIT-state watchdog: counts cycles without an ack and flags the last
// permitted cycle so the controller can abort the request.
module mem_timeout_cnt
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Holds at the terminal value so expired stays asserted until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: issues one request per load/store,
// stalls the pipeline until ack, and aborts with bus_err on misalignment or timeout.
//
// state | meaning
// IDLE  | no request outstanding; accept aligned memop, flag misaligned
// WAIT  | request on the bus, pipeline stalled, watchdog running
// DONE  | access completed, pipeline released for one cycle
// ABORT | watchdog expired, bus_err pulse, load data forced to zero
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned DW      = 32
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          memReadM,
    input  logic          DataMem_weM,
    input  logic          Regfile_weM,
    input  logic [DW-1:0] aluOutM,
    input  logic [DW-1:0] writeDataM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stallM,
    output logic [DW-1:0] readDataM,
    output logic          Regfile_weM_o,
    output logic          bus_err
);

    localparam logic [DW-1:0] ZERO_DW = ZERO_WORD[DW-1:0];

    mac_state_t    state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic memop;
    logic misaligned;
    logic cnt_clr;
    logic cnt_en;
    logic expired;
    logic stall_c;
    logic bus_err_c;
    logic rf_we_c;

    assign memop      = memReadM | DataMem_weM;
    assign misaligned = memop && (aluOutM[1:0] != 2'b00);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        stall_c   = 1'b0;
        bus_err_c = 1'b0;
        rf_we_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    bus_err_c = 1'b1;
                end else if (memop) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = DataMem_weM;
                    addr_d  = aluOutM;
                    wdata_d = writeDataM;
                    cnt_clr = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    rf_we_c = Regfile_weM;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_en  = !dmem_ack;
                // Ack is checked first so a last-cycle ack still completes.
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (expired) begin
                    req_d   = 1'b0;
                    rdata_d = ZERO_DW;
                    state_d = S_ABORT;
                end
            end
            S_DONE: begin
                rf_we_c = Regfile_weM;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                bus_err_c = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZERO_DW;
            wdata_q <= ZERO_DW;
            rdata_q <= ZERO_DW;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded outputs are masked by reset so a held memop cannot stall or flag during reset.
    assign stallM        = rst_n & stall_c;
    assign bus_err       = rst_n & bus_err_c;
    assign Regfile_weM_o = rst_n & rf_we_c;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign readDataM  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected completions,
// a negedge monitor pops and checks them when an access finishes.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memReadM = 1'b0;
    logic        DataMem_weM = 1'b0;
    logic        Regfile_weM = 1'b0;
    logic [31:0] aluOutM = '0;
    logic [31:0] writeDataM = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stallM;
    logic [31:0] readDataM;
    logic        Regfile_weM_o;
    logic        bus_err;

    mem_access_ctrl #(
        .TIMEOUT (TO),
        .DW      (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memReadM      (memReadM),
        .DataMem_weM   (DataMem_weM),
        .Regfile_weM   (Regfile_weM),
        .aluOutM       (aluOutM),
        .writeDataM    (writeDataM),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .stallM        (stallM),
        .readDataM     (readDataM),
        .Regfile_weM_o (Regfile_weM_o),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        rf_we;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          stall_cyc;
        int          req_cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   stall_cnt = 0;
    int   req_cnt = 0;
    logic stall_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memReadM    = 1'b0;
        DataMem_weM = 1'b0;
        Regfile_weM = 1'b0;
        aluOutM     = '0;
        writeDataM  = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;
    endtask

    // ack_at: WAIT cycle (1-based) carrying the ack; 0 means never ack.
    task automatic do_access(input logic is_store, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at,
                             input logic [31:0] rdata);
        exp_t e;
        int   n;
        e.we    = is_store;
        e.addr  = addr;
        e.wdata = is_store ? wdata : 32'h0;
        if (ack_at > 0) begin
            e.err       = 1'b0;
            e.rf_we     = !is_store;
            e.chk_rdata = !is_store;
            e.rdata     = rdata;
            e.stall_cyc = ack_at + 1;
            e.req_cyc   = ack_at;
            n           = ack_at;
        end else begin
            e.err       = 1'b1;
            e.rf_we     = 1'b0;
            e.chk_rdata = 1'b1;
            e.rdata     = 32'h0;
            e.stall_cyc = TO + 1;
            e.req_cyc   = TO;
            n           = TO;
        end
        exp_q.push_back(e);
        memReadM    = !is_store;
        DataMem_weM = is_store;
        Regfile_weM = !is_store;
        aluOutM     = addr;
        writeDataM  = e.wdata;
        for (int k = 1; k <= n; k++) begin
            cyc();
            dmem_ack   = (k == ack_at);
            dmem_rdata = (k == ack_at) ? rdata : 32'h0;
        end
        cyc();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        cyc();
        idle_inputs();
    endtask

    task automatic do_misaligned(input logic [31:0] addr);
        exp_t e;
        e.err       = 1'b1;
        e.rf_we     = 1'b0;
        e.chk_rdata = 1'b0;
        e.rdata     = 32'h0;
        e.stall_cyc = 0;
        e.req_cyc   = 0;
        e.we        = 1'b0;
        e.addr      = addr;
        e.wdata     = 32'h0;
        exp_q.push_back(e);
        memReadM    = 1'b1;
        Regfile_weM = 1'b1;
        aluOutM     = addr;
        cyc();
        idle_inputs();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt  = 0;
            req_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            if (dmem_req) begin
                req_cnt++;
                if (exp_q.size() > 0) begin
                    check("req_addr", dmem_addr, exp_q[0].addr);
                    check("req_wdata", dmem_wdata, exp_q[0].wdata);
                    check("req_we", {31'b0, dmem_we}, {31'b0, exp_q[0].we});
                end
            end
            if (stallM) stall_cnt++;
            if (bus_err || (stall_prev && !stallM)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: bus_err=%0b stallM=%0b with nothing expected at %0t",
                             bus_err, stallM, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
                    check("rf_we_o", {31'b0, Regfile_weM_o}, {31'b0, mon_e.rf_we});
                    check("stall_cycles", stall_cnt, mon_e.stall_cyc);
                    check("req_cycles", req_cnt, mon_e.req_cyc);
                    if (mon_e.chk_rdata) check("read_data", readDataM, mon_e.rdata);
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end
            stall_prev = stallM;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n       = 1'b0;
        memReadM    = 1'b1;
        Regfile_weM = 1'b1;
        aluOutM     = 32'h10;
        #12;
        check("rst_req", {31'b0, dmem_req}, 32'h0);
        check("rst_we", {31'b0, dmem_we}, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_rdata", readDataM, 32'h0);
        check("rst_stall", {31'b0, stallM}, 32'h0);
        aluOutM = 32'h33;
        #1;
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        idle_inputs();
        cyc();
        rst_n = 1'b1;

        // IDLE with no memop: write enable passes through, ack ignored.
        Regfile_weM = 1'b1;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        #2;
        check("idle_rf_we", {31'b0, Regfile_weM_o}, 32'h1);
        cyc();
        idle_inputs();
        #2;
        check("idle_ack_req", {31'b0, dmem_req}, 32'h0);
        check("idle_ack_rdata", readDataM, 32'h0);

        do_access(1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF);
        do_access(1'b1, 32'h20, 32'h1234_5678, 5, 32'h0);
        do_misaligned(32'h33);
        do_access(1'b0, 32'h40, 32'h0, 0, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        cyc();
        idle_inputs();
        #1;
        check("late_ack_rdata", readDataM, 32'h0);
        check("late_ack_req", {31'b0, dmem_req}, 32'h0);

        // Reset in the third WAIT cycle of a load that never gets acked.
        memReadM    = 1'b1;
        Regfile_weM = 1'b1;
        aluOutM     = 32'h50;
        cyc();
        cyc();
        cyc();
        #1;
        check("pre_rst_req", {31'b0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, dmem_req}, 32'h0);
        check("mid_rst_stall", {31'b0, stallM}, 32'h0);
        check("mid_rst_addr", dmem_addr, 32'h0);
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        do_access(1'b0, 32'h54, 32'h0, 1, 32'hCAFE_F00D);

        do_access(1'b0, 32'h60, 32'h0, TO, 32'hA5A5_5A5A);
        do_access(1'b1, 32'h7C, 32'h0F0F_0F0F, 3, 32'h0);

        cyc();
        cyc();
        cyc();
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
